// File: rtl/apx_float_adder_driver.sv
// Handshake driver for an approximate float adder: queues operand pairs,
// runs one add at a time and queues results with truncated mantissa LSBs.
module apx_float_adder_driver #(
    parameter int DEPTH = 4,
    parameter int NAB_M = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_valid,
    output logic        op_ready,
    output logic [31:0] res_z,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] output_a,
    output logic        output_a_stb,
    input  logic        output_a_ack,
    output logic [31:0] output_b,
    output logic        output_b_stb,
    input  logic        output_b_ack,
    input  logic [31:0] input_z,
    input  logic        input_z_stb,
    output logic        input_z_ack,
    output logic        busy,
    output logic [15:0] done_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [31:0] KEEP_MASK = 32'hFFFF_FFFF << NAB_M;

    typedef enum logic [1:0] {
        IDLE,
        SEND_A,
        SEND_B,
        GET_Z
    } state_t;

    state_t state;

    logic [63:0]   op_mem  [DEPTH];
    logic [31:0]   res_mem [DEPTH];
    logic [AW-1:0] op_wr;
    logic [AW-1:0] op_rd;
    logic [AW-1:0] res_wr;
    logic [AW-1:0] res_rd;
    logic [AW:0]   op_cnt;
    logic [AW:0]   res_cnt;
    logic          op_push;
    logic          op_pop;
    logic          res_push;
    logic          res_pop;

    // A pop on this edge frees a slot, so a full operand FIFO still accepts.
    assign op_pop   = (state == SEND_B) && output_b_ack;
    assign op_ready = (op_cnt != FULL) || op_pop;
    assign op_push  = op_valid && op_ready;

    assign input_z_ack = (state == GET_Z) && (res_cnt != FULL);
    assign res_push    = input_z_stb && input_z_ack;
    assign res_valid   = (res_cnt != '0);
    assign res_pop     = res_valid && res_ready;
    assign res_z       = res_mem[res_rd];

    assign output_a     = op_mem[op_rd][63:32];
    assign output_b     = op_mem[op_rd][31:0];
    assign output_a_stb = (state == SEND_A);
    assign output_b_stb = (state == SEND_B);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (op_push) begin
            op_mem[op_wr] <= {op_a, op_b};
        end
        if (res_push) begin
            res_mem[res_wr] <= input_z & KEEP_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr   <= '0;
            op_rd   <= '0;
            op_cnt  <= '0;
            res_wr  <= '0;
            res_rd  <= '0;
            res_cnt <= '0;
        end else begin
            if (op_push) begin
                op_wr <= op_wr + PTR_ONE;
            end
            if (op_pop) begin
                op_rd <= op_rd + PTR_ONE;
            end
            case ({op_push, op_pop})
                2'b10:   op_cnt <= op_cnt + CNT_ONE;
                2'b01:   op_cnt <= op_cnt - CNT_ONE;
                default: op_cnt <= op_cnt;
            endcase
            if (res_push) begin
                res_wr <= res_wr + PTR_ONE;
            end
            if (res_pop) begin
                res_rd <= res_rd + PTR_ONE;
            end
            case ({res_push, res_pop})
                2'b10:   res_cnt <= res_cnt + CNT_ONE;
                2'b01:   res_cnt <= res_cnt - CNT_ONE;
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_cnt != '0) begin
                        state <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (output_a_ack) begin
                        state <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (output_b_ack) begin
                        state <= GET_Z;
                    end
                end
                GET_Z: begin
                    if (res_push) begin
                        state      <= IDLE;
                        done_count <= done_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apx_float_adder_driver.sv
// Directed bench for apx_float_adder_driver with a handshaking adder model
// whose result is a ^ b ^ z_bias.
module tb_apx_float_adder_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] res_z;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] output_a;
    logic        output_a_stb;
    logic        output_a_ack = 1'b0;
    logic [31:0] output_b;
    logic        output_b_stb;
    logic        output_b_ack = 1'b0;
    logic [31:0] input_z = '0;
    logic        input_z_stb = 1'b0;
    logic        input_z_ack;
    logic        busy;
    logic [15:0] done_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic        adder_en = 1'b1;
    logic        spur = 1'b0;
    logic        mdl_flush = 1'b0;
    int          a_delay = 0;
    logic [31:0] z_bias = '0;
    int          a_cnt = 0;
    int          a_xfers = 0;
    logic [31:0] a_lat = '0;
    logic [31:0] b_lat = '0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_b = '0;
    logic        prev_a_stb = 1'b0;
    logic        prev_b_stb = 1'b0;
    logic        prev_z_stb = 1'b0;
    logic        prev_z_ack = 1'b0;
    logic        z_pend = 1'b0;

    logic [31:0] bp_a   [5];
    logic [31:0] bp_exp [5];
    logic [15:0] exp_done;
    int          xf0;

    apx_float_adder_driver dut (
        .clk         (clk),
        .rst         (rst),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .res_z       (res_z),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .output_a    (output_a),
        .output_a_stb(output_a_stb),
        .output_a_ack(output_a_ack),
        .output_b    (output_b),
        .output_b_stb(output_b_stb),
        .output_b_ack(output_b_ack),
        .input_z     (input_z),
        .input_z_stb (input_z_stb),
        .input_z_ack (input_z_ack),
        .busy        (busy),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    // Adder model: acts on falling edges; strobes are stable between rising edges.
    always @(negedge clk) begin
        if (!rst && prev_a_stb && output_a_ack) begin
            a_lat = prev_a;
            a_xfers++;
        end
        if (!rst && prev_b_stb && output_b_ack) begin
            b_lat = prev_b;
            z_pend = 1'b1;
        end
        if (!rst && prev_z_stb && prev_z_ack) begin
            input_z_stb = 1'b0;
        end
        if (mdl_flush) begin
            z_pend = 1'b0;
            input_z_stb = 1'b0;
        end
        if (z_pend && !input_z_stb) begin
            input_z_stb = 1'b1;
            input_z = a_lat ^ b_lat ^ z_bias;
            z_pend = 1'b0;
        end
        if (output_a_stb && adder_en) begin
            output_a_ack = (a_cnt >= a_delay);
            a_cnt++;
        end else begin
            output_a_ack = 1'b0;
            a_cnt = 0;
        end
        if (spur) begin
            output_a_ack = 1'b1;
        end
        output_b_ack = spur || (output_b_stb && adder_en);
        prev_a_stb = output_a_stb;
        prev_b_stb = output_b_stb;
        prev_z_stb = input_z_stb;
        prev_z_ack = input_z_ack;
        prev_a = output_a;
        prev_b = output_b;
    end

    task automatic step;
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int i;
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        i = 0;
        while (!op_ready && i < 200) begin
            step();
            i++;
        end
        check("send_rdy", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
    endtask

    task automatic get(input string tag, input logic [31:0] exp);
        int i;
        i = 0;
        while (!res_valid && i < 300) begin
            step();
            i++;
        end
        check({tag, "_v"}, 32'(res_valid), 32'd1);
        check(tag, res_z, exp);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bp_a[0] = 32'h1000_0000; bp_exp[0] = 32'h1AB0_0000;
        bp_a[1] = 32'h2000_0000; bp_exp[1] = 32'h2AB0_0000;
        bp_a[2] = 32'h3000_0000; bp_exp[2] = 32'h3AB0_0000;
        bp_a[3] = 32'h4000_0000; bp_exp[3] = 32'h4AB0_0000;
        bp_a[4] = 32'h5000_0000; bp_exp[4] = 32'h5AB0_0000;

        // reset state
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rvalid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(op_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done_count), 32'd0);
        check("post_rst_astb", 32'(output_a_stb), 32'd0);
        check("post_rst_bstb", 32'(output_b_stb), 32'd0);
        check("post_rst_zack", 32'(input_z_ack), 32'd0);

        // single op and issue latency
        z_bias = 32'h400F_FFFF;
        op_a = 32'h3F80_0000;
        op_b = 32'h3F80_0000;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        check("lat_t1", 32'(output_a_stb), 32'd0);
        step();
        check("lat_t2", 32'(output_a_stb), 32'd1);
        check("lat_opa", output_a, 32'h3F80_0000);
        get("single", 32'h4000_0000);
        exp_done = 16'd1;
        check("single_done", 32'(done_count), 32'(exp_done));

        // backpressure: four queued ops, fifth pushed as the first pops
        z_bias = '0;
        adder_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(bp_a[k], 32'h0ABC_DEF1);
        end
        check("op_full", 32'(op_ready), 32'd0);
        op_a = bp_a[4];
        op_valid = 1'b1;
        adder_en = 1'b1;
        for (int i = 0; i < 50 && !op_ready; i++) begin
            step();
        end
        check("op5_rdy", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
        check("simul_full", 32'(op_ready), 32'd0);
        for (int i = 0; i < 300 &&
             !(done_count == exp_done + 16'd4 && input_z_stb); i++) begin
            step();
        end
        step();
        step();
        check("z_stall_ack", 32'(input_z_ack), 32'd0);
        check("z_stall_done", 32'(done_count), 32'(exp_done + 16'd4));
        check("bp_res0", res_z, bp_exp[0]);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("z_ack_rise", 32'(input_z_ack), 32'd1);
        for (int k = 1; k < 5; k++) begin
            get($sformatf("bp_res%0d", k), bp_exp[k]);
        end
        exp_done = exp_done + 16'd5;
        check("bp_done", 32'(done_count), 32'(exp_done));

        // slow adder on operand A
        a_delay = 7;
        xf0 = a_xfers;
        send(32'hC0DE_0000, 32'h0000_0F0F);
        for (int i = 0; i < 50 && !output_a_stb; i++) begin
            step();
        end
        for (int i = 0; i < 7; i++) begin
            check($sformatf("slow_stb%0d", i), 32'(output_a_stb), 32'd1);
            check($sformatf("slow_a%0d", i), output_a, 32'hC0DE_0000);
            step();
        end
        for (int i = 0; i < 50 && !output_b_stb; i++) begin
            step();
        end
        check("slow_b", output_b, 32'h0000_0F0F);
        get("slow_res", 32'hC0D0_0000);
        check("slow_xfers", 32'(a_xfers - xf0), 32'd1);
        a_delay = 0;

        // reset while a result is strobed in GET_Z
        send(32'h1234_5678, 32'h0000_0000);
        for (int i = 0; i < 50 && !(input_z_stb && busy); i++) begin
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("zrst_busy", 32'(busy), 32'd0);
        check("zrst_rvalid", 32'(res_valid), 32'd0);
        check("zrst_done", 32'(done_count), 32'd0);
        check("zrst_zack", 32'(input_z_ack), 32'd0);
        repeat (3) step();
        check("zrst_nopush", 32'(res_valid), 32'd0);
        mdl_flush = 1'b1;
        step();
        mdl_flush = 1'b0;
        send(32'h0F0F_0000, 32'h00F0_0000);
        get("post_zrst", 32'h0FF0_0000);
        check("post_zrst_done", 32'(done_count), 32'd1);

        // unqualified acks while idle and empty
        spur = 1'b1;
        repeat (3) step();
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_ready", 32'(op_ready), 32'd1);
        spur = 1'b0;
        step();

        // done_count wrap
        force dut.done_count = 16'hFFFF;
        step();
        release dut.done_count;
        step();
        z_bias = 32'h400F_FFFF;
        send(32'h3F80_0000, 32'h3F80_0000);
        get("wrap_res", 32'h4000_0000);
        check("wrap_done", 32'(done_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apx_float_adder_driver.md
APX_FLOAT_ADDER_DRIVER -- requirements
Module: apx_float_adder_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the entry count of both the operand FIFO and the result FIFO (power of two, 2..16).
REQ-002 SHALL have parameter NAB_M, default 20, meaning the number of result mantissa LSBs forced to zero.
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- op_a  in  32  host operand A
- op_b  in  32  host operand B
- op_valid  in  1  host pair offered
- op_ready  out  1  operand FIFO not full
- res_z  out  32  result FIFO head
- res_valid  out  1  result FIFO not empty
- res_ready  in  1  host pops result
- output_a  out  32  operand A to adder
- output_a_stb  out  1  A strobe
- output_a_ack  in  1  adder accepts A
- output_b  out  32  operand B to adder
- output_b_stb  out  1  B strobe
- output_b_ack  in  1  adder accepts B
- input_z  in  32  adder result
- input_z_stb  in  1  result strobe
- input_z_ack  out  1  driver accepts result
- busy  out  1  state != IDLE
- done_count  out  16  results captured

Function
REQ-005 SHALL push {op_a,op_b} into the operand FIFO on a rising edge where op_valid && op_ready.
REQ-006 SHALL pop the result FIFO on a rising edge where res_valid && res_ready; res_z SHALL show the head entry combinationally.
REQ-007 SHALL allow a push and a pop in the same cycle on either FIFO, including when it is full or empty; the count SHALL stay unchanged when both occur, and the FIFO pointers SHALL wrap modulo DEPTH.
REQ-008 SHALL implement the states IDLE, SEND_A, SEND_B and GET_Z, with one operation in flight at most.
REQ-009 State transitions:
- IDLE -> SEND_A on an edge where the operand FIFO is not empty.
- SEND_A -> SEND_B on an edge where output_a_stb && output_a_ack.
- SEND_B -> GET_Z on an edge where output_b_stb && output_b_ack; the operand FIFO pops on the same edge.
- GET_Z -> IDLE on an edge where input_z_stb && input_z_ack.
REQ-010 SHALL drive the strobes and result acknowledge as follows:
- output_a_stb = (state == SEND_A).
- output_b_stb = (state == SEND_B).
- input_z_ack = (state == GET_Z) && result FIFO not full.
REQ-011 SHALL hold output_a and output_b at the operand FIFO head, stable, while the corresponding strobe is high.
REQ-012 SHALL push {input_z[31:NAB_M], NAB_M zeros} into the result FIFO on the GET_Z transfer edge, and SHALL increment done_count on that edge, wrapping 0xFFFF -> 0x0000.
REQ-013 SHALL stall in GET_Z with input_z_ack low while the result FIFO is full; a pop on the same edge SHALL let input_z_ack rise in the following cycle.
REQ-014 SHALL ignore an ack that is not qualified by its own strobe, e.g. output_a_ack in IDLE, output_b_ack in SEND_A, or input_z_stb outside GET_Z.
REQ-015 Latency from op_valid accept edge t:
- output_a_stb is high in the cycle after edge t+1 when the FIFO was empty and the state was IDLE.
- The driver adds no further delay beyond the adder's handshake.
REQ-016 SHALL keep operand order: results SHALL leave res_z in the order their operands were accepted.

Reset
REQ-017 rst high at a rising edge SHALL set the following, overriding any other update on that edge:
- state IDLE;
- both FIFOs empty;
- done_count 0;
- output_a_stb, output_b_stb, input_z_ack, res_valid and busy all 0.
REQ-018 op_ready SHALL be 1 in the first cycle after reset.
REQ-019 Reset asserted mid-operation (any state) SHALL drop the operation in flight; any result strobed by the adder afterwards SHALL be ignored until a new operation reaches GET_Z.
REQ-020 The values of output_a and output_b during and after reset SHALL be don't-care.

Verification
REQ-021 Single op: op_a=0x3F800000, op_b=0x3F800000; adder model returns 0x400FFFFF -> res_z=0x40000000, res_valid=1, done_count=1.
REQ-022 Backpressure: res_ready=0, 5 ops with DEPTH=4:
- op_ready drops after 4 FIFO entries;
- the 5th op waits in GET_Z with input_z_ack=0;
- one pop -> input_z_ack=1 the next cycle, and results leave in order.
REQ-023 Slow adder: output_a_ack delayed 7 cycles -> output_a_stb held high and output_a unchanged for 7 cycles; exactly one transfer occurs.
REQ-024 Reset in GET_Z: assert rst for 1 cycle while input_z_stb is pending ->
- busy=0, res_valid=0, done_count=0;
- no result is pushed;
- the next op completes normally.
REQ-025 Simultaneous events: op FIFO full with a push and a pop on the same edge -> count stays 4; done_count wrap is forced from 0xFFFF -> 0x0000 on the next result.
